// File: rtl/mem_arb_ctrl_if.sv
// Requester and RAM-side signal bundle for mem_arb_ctrl; the controller uses the slave view.
// Per-port request fields are packed flat, port p at [p*W +: W].
interface mem_arb_ctrl_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) ();
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*3-1:0]      req_len;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic [7:0]                  ram_rdata;
    logic                        ram_rw;
    logic [ADDR_W-1:0]           ram_addr;
    logic [7:0]                  ram_wdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_len, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, ram_rw, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_len, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, ram_rw, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Arbitrates NUM_PORTS byte-serial read/write requesters onto one 8-bit RAM port.
// Latency: read n+2, write n+1, len0 1 cycle to rsp; rdy_in low freezes everything and drops ready.
module mem_arb_ctrl #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    mem_arb_ctrl_if.slave bus
);
    localparam int MAXB = DATA_W / 8;
    localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [CW-1:0]     len_q, len_nxt;
    logic [PW-1:0]     port_q, port_nxt;
    logic [PW-1:0]     last_grant, last_grant_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              rsp_q, rsp_nxt;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;

    logic [PW-1:0]     grant;
    logic              grant_vld;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        sel_len;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic [CW-1:0]     len_eff;
    logic [DATA_W-1:0] rd_fill;
    logic [DATA_W-1:0] wr_shift;
    logic              addr_drive;

    // Round-robin search begins one past the last accepted port; fixed mode always starts at 0.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (PRIO_MODE == 1) begin
                idx = (int'(last_grant) + 1 + i) % NUM_PORTS;
            end else begin
                idx = i;
            end
            if (!grant_vld && bus.req_valid[idx]) begin
                grant     = PW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    assign accept = grant_vld && (state == IDLE) && rdy_in;

    always_comb begin
        bus.req_ready = '0;
        if (grant_vld && (state == IDLE) && rdy_in && rst_in) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    assign sel_addr  = bus.req_addr[int'(grant)*ADDR_W +: ADDR_W];
    assign sel_len   = bus.req_len[int'(grant)*3 +: 3];
    assign sel_wdata = bus.req_wdata[int'(grant)*DATA_W +: DATA_W];
    assign sel_we    = bus.req_we[grant];
    assign len_eff   = (int'(sel_len) > MAXB) ? CW'(MAXB) : CW'(sel_len);

    // RAM data lags the address by one cycle, so the byte arriving while cnt==k belongs to k-1.
    always_comb begin
        rd_fill = data_q;
        for (int b = 0; b < MAXB; b++) begin
            if (cnt == CW'(b + 1)) begin
                rd_fill[8*b +: 8] = bus.ram_rdata;
            end
        end
    end

    assign wr_shift = data_q >> {cnt, 3'b000};

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        len_nxt        = len_q;
        port_nxt       = port_q;
        last_grant_nxt = last_grant;
        addr_nxt       = addr_q;
        data_nxt       = data_q;
        rsp_nxt        = 1'b0;
        rdata_nxt      = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    port_nxt       = grant;
                    last_grant_nxt = grant;
                    addr_nxt       = sel_addr;
                    len_nxt        = len_eff;
                    cnt_nxt        = '0;
                    data_nxt       = sel_we ? sel_wdata : '0;
                    if (len_eff == '0) begin
                        rsp_nxt = 1'b1;
                    end else begin
                        state_nxt = sel_we ? WRITE : READ;
                    end
                end
            end
            READ: begin
                data_nxt = rd_fill;
                if (cnt == len_q) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    rsp_nxt   = 1'b1;
                    rdata_nxt = rd_fill;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WRITE: begin
                if (cnt == len_q - CW'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    rsp_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            cnt        <= '0;
            len_q      <= '0;
            port_q     <= '0;
            last_grant <= PW'(NUM_PORTS - 1);
            addr_q     <= '0;
            data_q     <= '0;
            rsp_q      <= 1'b0;
            rdata_q    <= '0;
        end else if (rdy_in) begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            len_q      <= len_nxt;
            port_q     <= port_nxt;
            last_grant <= last_grant_nxt;
            addr_q     <= addr_nxt;
            data_q     <= data_nxt;
            rsp_q      <= rsp_nxt;
            rdata_q    <= rdata_nxt;
        end
    end

    // The extra READ cycle after the last address only captures data, so the bus goes quiet.
    assign addr_drive    = (state == WRITE) || ((state == READ) && (cnt < len_q));
    assign bus.ram_rw    = (state == WRITE);
    assign bus.ram_addr  = addr_drive ? (addr_q + ADDR_W'(cnt)) : '0;
    assign bus.ram_wdata = (state == WRITE) ? wr_shift[7:0] : 8'h00;
    assign bus.rsp_rdata = rdata_q;

    always_comb begin
        bus.rsp_valid = '0;
        if (rsp_q) begin
            bus.rsp_valid[port_q] = 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed plus randomized bench for mem_arb_ctrl against a transaction-level RAM/arbiter model.
module tb_mem_arb_ctrl;
    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAXB = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic rdy   = 1'b1;
    always #5 clk = ~clk;

    mem_arb_ctrl_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus_r ();
    mem_arb_ctrl_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus_f ();

    mem_arb_ctrl #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut_rr (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .bus(bus_r)
    );
    mem_arb_ctrl #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut_fx (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .bus(bus_f)
    );

    assign bus_f.req_valid = bus_r.req_valid;
    assign bus_f.req_we    = bus_r.req_we;
    assign bus_f.req_addr  = bus_r.req_addr;
    assign bus_f.req_len   = bus_r.req_len;
    assign bus_f.req_wdata = bus_r.req_wdata;
    assign bus_f.ram_rdata = 8'h00;

    logic [7:0] ram     [bit [31:0]];
    logic [7:0] ref_mem [bit [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Synchronous RAM: read data one cycle after address; frozen with the rest of the system.
    always @(posedge clk) begin
        if (rdy) begin
            bus_r.ram_rdata <= ram_rd(bus_r.ram_addr);
            if (bus_r.ram_rw) ram[bus_r.ram_addr] = bus_r.ram_wdata;
        end
    end

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s c%0d got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One request on port p; the caller is just past a negedge with the DUT idle.
    // rdy drops after sampling cycle s and returns after sampling cycle s+L.
    task automatic do_txn(input int p, input bit we, input logic [31:0] a, input int len,
                          input logic [31:0] wd, input int s, input int l_in,
                          input string tag, output logic [31:0] got_rd);
        int n, r, e, L;
        logic [NP-1:0] oh;
        logic [31:0]   exp_rd, tmp;
        bit            in_rng;
        n = (len > MAXB) ? MAXB : len;
        r = (n == 0) ? 1 : (we ? n + 1 : n + 2);
        L = (s >= r) ? 0 : l_in;
        oh = '0;
        oh[p] = 1'b1;
        exp_rd = '0;
        got_rd = '0;
        for (int k = 0; k < n; k++) begin
            if (we) ref_mem[a + 32'(k)] = wd[8*k +: 8];
            else    exp_rd[8*k +: 8] = ref_rd(a + 32'(k));
        end
        bus_r.req_valid = '0;
        bus_r.req_valid[p] = 1'b1;
        bus_r.req_we[p] = we;
        bus_r.req_addr[p*AW +: AW] = a;
        bus_r.req_len[p*3 +: 3] = 3'(len);
        bus_r.req_wdata[p*DW +: DW] = wd;
        #1;
        chk({tag, " ready"}, 0, 32'(bus_r.req_ready), 32'(oh));
        @(posedge clk);
        #1;
        bus_r.req_valid = '0;
        bus_r.req_we = NP'($urandom);
        bus_r.req_addr = {NP{$urandom}};
        bus_r.req_len = 6'($urandom);
        bus_r.req_wdata = {NP{$urandom}};
        for (int c = 1; c <= r + L; c++) begin
            @(negedge clk);
            e = (c <= s) ? c : ((c <= s + L) ? s : c - L);
            in_rng = (e >= 1) && (e <= n);
            chk({tag, " rw"}, c, 32'(bus_r.ram_rw), 32'(we && in_rng));
            if (in_rng || e == r) begin
                tmp = wd >> (8 * (e - 1));
                chk({tag, " addr"}, c, bus_r.ram_addr, in_rng ? a + 32'(e - 1) : 32'h0);
                chk({tag, " wbyte"}, c, 32'(bus_r.ram_wdata), (we && in_rng) ? 32'(tmp[7:0]) : 32'h0);
            end
            chk({tag, " rsp"}, c, 32'(bus_r.rsp_valid), (e == r) ? 32'(oh) : 32'h0);
            if (e == r) begin
                chk({tag, " rdata"}, c, bus_r.rsp_rdata, exp_rd);
                got_rd = bus_r.rsp_rdata;
            end
            if (L > 0 && c == s) rdy = 1'b0;
            if (L > 0 && c == s + L) rdy = 1'b1;
        end
    endtask

    initial begin
        logic [31:0]   got;
        logic [NP-1:0] exp_oh, prev_oh;
        int            last, g, mism, s, l, ln, pp;
        bit            wr;
        logic [31:0]   aa;

        bus_r.req_valid = '0;
        bus_r.req_we    = '0;
        bus_r.req_addr  = '0;
        bus_r.req_len   = '0;
        bus_r.req_wdata = '0;
        for (int k = 0; k < 4; k++) begin
            ram[32'h100 + 32'(k)]     = 8'h11 * 8'(k + 1);
            ref_mem[32'h100 + 32'(k)] = 8'h11 * 8'(k + 1);
        end

        #1 rst_n = 1'b0;
        bus_r.req_valid = 2'b11;
        #2;
        chk("reset ready", 0, 32'(bus_r.req_ready), 32'h0);
        chk("reset ready fx", 0, 32'(bus_f.req_ready), 32'h0);
        chk("reset rsp", 0, 32'(bus_r.rsp_valid), 32'h0);
        chk("reset rdata", 0, bus_r.rsp_rdata, 32'h0);
        chk("reset rw", 0, 32'(bus_r.ram_rw), 32'h0);
        chk("reset addr", 0, bus_r.ram_addr, 32'h0);
        chk("reset wbyte", 0, 32'(bus_r.ram_wdata), 32'h0);
        @(negedge clk);
        @(negedge clk);
        bus_r.req_valid = '0;
        rst_n = 1'b1;

        do_txn(1, 1'b0, 32'h100, 4, 32'h0, 0, 0, "rd4", got);
        chk("rd4 const", 0, got, 32'h4433_2211);
        do_txn(0, 1'b1, 32'h2000, 2, 32'hA5B6_C7D8, 0, 0, "wr2", got);
        chk("wr2 ram0", 0, 32'(ram_rd(32'h2000)), 32'hD8);
        chk("wr2 ram1", 0, 32'(ram_rd(32'h2001)), 32'hC7);
        chk("wr2 untouched", 0, 32'(ram.exists(32'h2002)), 32'h0);
        do_txn(0, 1'b0, 32'hFFFF_FFFF, 2, 32'h0, 0, 0, "rdwrap", got);
        chk("rdwrap upper", 0, got & 32'hFFFF_0000, 32'h0);
        do_txn(1, 1'b0, 32'h500, 0, 32'h0, 0, 0, "len0", got);
        do_txn(0, 1'b0, 32'h100, 7, 32'h0, 0, 0, "len7", got);
        do_txn(0, 1'b1, 32'h3000, 4, 32'h1122_3344, 2, 3, "wrstall", got);

        // Reset in the middle of a read: everything drops, no completion follows.
        bus_r.req_valid = 2'b10;
        bus_r.req_we = '0;
        bus_r.req_addr[AW +: AW] = 32'h100;
        bus_r.req_len[3 +: 3] = 3'd4;
        @(posedge clk);
        #1 bus_r.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst pre addr", 2, bus_r.ram_addr, 32'h101);
        rst_n = 1'b0;
        bus_r.req_valid = 2'b11;
        #1;
        chk("midrst ready", 2, 32'(bus_r.req_ready), 32'h0);
        chk("midrst addr", 2, bus_r.ram_addr, 32'h0);
        chk("midrst rw", 2, 32'(bus_r.ram_rw), 32'h0);
        chk("midrst rsp", 2, 32'(bus_r.rsp_valid), 32'h0);
        @(negedge clk);
        bus_r.req_valid = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("midrst norsp", c, 32'(bus_r.rsp_valid), 32'h0);
        end

        // Both ports always valid with zero-length requests: one acceptance per cycle.
        bus_r.req_valid = 2'b11;
        bus_r.req_we = 2'b11;
        bus_r.req_len = '0;
        last = NP - 1;
        prev_oh = '0;
        #1;
        for (int i = 0; i < 6; i++) begin
            g = -1;
            for (int k = 1; k <= NP; k++) begin
                if (g < 0 && bus_r.req_valid[(last + k) % NP]) g = (last + k) % NP;
            end
            exp_oh = '0;
            exp_oh[g] = 1'b1;
            chk("rr grant", i, 32'(bus_r.req_ready), 32'(exp_oh));
            chk("rr rsp", i, 32'(bus_r.rsp_valid), 32'(prev_oh));
            chk("fx grant", i, 32'(bus_f.req_ready), 32'h1);
            if (i > 0) chk("fx rsp", i, 32'(bus_f.rsp_valid), 32'h1);
            prev_oh = exp_oh;
            last = g;
            @(negedge clk);
            #1;
        end
        bus_r.req_valid = '0;
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            pp = int'($urandom_range(0, NP - 1));
            wr = 1'($urandom_range(0, 1));
            aa = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                             : 32'h4000 + 32'($urandom_range(0, 31));
            ln = int'($urandom_range(0, 7));
            s  = int'($urandom_range(1, 8));
            l  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_txn(pp, wr, aa, ln, $urandom, s, l, "rand", got);
        end

        mism = 0;
        foreach (ref_mem[k]) begin
            if (ram_rd(k) !== ref_mem[k]) mism++;
        end
        chk("ram contents", 0, 32'(mism), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
